// File: rtl/fit_residual_sequencer.sv
// fit_residual_sequencer: reads one event's residual words from the fit-input
// buffer, groups consecutive words by track ID and emits one summary record
// per track (layer mask, stub count, saturated phi/z sums), then pulses done.
module fit_residual_sequencer #(
    parameter int RD_LAT = 1,
    parameter int SUM_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       number,
    input  logic [35:0]      res_in,
    output logic             read_en,
    output logic             track_valid,
    output logic [6:0]       track_id,
    output logic [5:0]       layer_mask,
    output logic [2:0]       nstubs,
    output logic [SUM_W-1:0] sum_phi,
    output logic [SUM_W-1:0] sum_z,
    output logic             dup_flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FLUSH} state_t;

    // The drain wait is RD_LAT cycles; an empty event also takes this path so
    // that its done pulse lands at the same offset as a one-word event minus one.
    localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [5:0]         rd_rem_q, rd_rem_d;
    logic [2:0]         drain_q, drain_d;
    logic [RD_LAT-1:0]  pipe_q, pipe_d, pipe_shift;

    // Open (accumulating) track
    logic               open_q, open_d;
    logic [6:0]         trk_id_q, trk_id_d;
    logic [5:0]         trk_mask_q, trk_mask_d;
    logic [2:0]         trk_nst_q, trk_nst_d;
    logic [SUM_W-1:0]   trk_phi_q, trk_phi_d;
    logic [SUM_W-1:0]   trk_z_q, trk_z_d;
    logic               trk_dup_q, trk_dup_d;

    // Registered record (emitted on an ID change, held between strobes)
    logic               out_valid_q, out_valid_d;
    logic [6:0]         out_id_q, out_id_d;
    logic [5:0]         out_mask_q, out_mask_d;
    logic [2:0]         out_nst_q, out_nst_d;
    logic [SUM_W-1:0]   out_phi_q, out_phi_d;
    logic [SUM_W-1:0]   out_z_q, out_z_d;
    logic               out_dup_q, out_dup_d;

    logic               capture, fresh, flush_emit;
    logic [7:0]         lbit;
    logic [5:0]         acc_mask;
    logic [2:0]         acc_nst;
    logic [SUM_W-1:0]   acc_phi, acc_z;
    logic               acc_dup;

    // Add a 13-bit signed residual to the running sum, clamping instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                 input logic [12:0] res);
        logic [SUM_W:0] s;
        s = {acc[SUM_W-1], acc} + {{(SUM_W-12){res[12]}}, res};
        if (s[SUM_W] != s[SUM_W-1])
            sat_add = s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        else
            sat_add = s[SUM_W-1:0];
    endfunction

    // Latency pipe: bit k is the read strobe delayed by k+1 cycles
    assign pipe_shift[0] = read_en;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            assign pipe_shift[gi] = pipe_q[gi-1];
        end
    endgenerate

    assign read_en    = (state_q == S_READ);
    assign busy       = (state_q != S_IDLE);
    // A record strobed from the ID-change path in FLUSH pushes the last track one cycle later
    assign flush_emit = (state_q == S_FLUSH) && open_q && !out_valid_q;
    assign done       = (state_q == S_FLUSH) && !(out_valid_q && open_q);
    assign capture    = pipe_q[RD_LAT-1] && (res_in != '0) && !start;

    assign track_valid = out_valid_q | flush_emit;
    assign track_id    = flush_emit ? trk_id_q   : out_id_q;
    assign layer_mask  = flush_emit ? trk_mask_q : out_mask_q;
    assign nstubs      = flush_emit ? trk_nst_q  : out_nst_q;
    assign sum_phi     = flush_emit ? trk_phi_q  : out_phi_q;
    assign sum_z       = flush_emit ? trk_z_q    : out_z_q;
    assign dup_flag    = flush_emit ? trk_dup_q  : out_dup_q;

    // Next-state, grouping/accumulation and record hand-off
    always_comb begin
        state_d     = state_q;
        rd_rem_d    = rd_rem_q;
        drain_d     = drain_q;
        pipe_d      = pipe_shift;
        open_d      = open_q;
        trk_id_d    = trk_id_q;
        trk_mask_d  = trk_mask_q;
        trk_nst_d   = trk_nst_q;
        trk_phi_d   = trk_phi_q;
        trk_z_d     = trk_z_q;
        trk_dup_d   = trk_dup_q;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_mask_d  = out_mask_q;
        out_nst_d   = out_nst_q;
        out_phi_d   = out_phi_q;
        out_z_d     = out_z_q;
        out_dup_d   = out_dup_q;
        fresh       = 1'b0;
        lbit        = 8'd0;
        acc_mask    = 6'd0;
        acc_nst     = 3'd0;
        acc_phi     = '0;
        acc_z       = '0;
        acc_dup     = 1'b0;

        case (state_q)
            S_READ: begin
                rd_rem_d = rd_rem_q - 6'd1;
                if (rd_rem_q == 6'd1)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_q == 3'd0)
                    state_d = S_FLUSH;
                else
                    drain_d = drain_q - 3'd1;
            end
            S_FLUSH: begin
                if (done)
                    state_d = S_IDLE;
            end
            default: ;
        endcase

        if (capture) begin
            fresh = !open_q || (res_in[35:29] != trk_id_q);
            if (open_q && fresh) begin
                out_valid_d = 1'b1;
                out_id_d    = trk_id_q;
                out_mask_d  = trk_mask_q;
                out_nst_d   = trk_nst_q;
                out_phi_d   = trk_phi_q;
                out_z_d     = trk_z_q;
                out_dup_d   = trk_dup_q;
            end
            if (!fresh) begin
                acc_mask = trk_mask_q;
                acc_nst  = trk_nst_q;
                acc_phi  = trk_phi_q;
                acc_z    = trk_z_q;
                acc_dup  = trk_dup_q;
            end
            lbit = 8'd1 << res_in[28:26];
            if ((res_in[28:26] >= 3'd6) || ((acc_mask & lbit[5:0]) != 6'd0)) begin
                acc_dup = 1'b1;
            end else begin
                acc_mask = acc_mask | lbit[5:0];
                acc_nst  = acc_nst + 3'd1;
                acc_phi  = sat_add(acc_phi, res_in[25:13]);
                acc_z    = sat_add(acc_z, res_in[12:0]);
            end
            open_d     = 1'b1;
            trk_id_d   = res_in[35:29];
            trk_mask_d = acc_mask;
            trk_nst_d  = acc_nst;
            trk_phi_d  = acc_phi;
            trk_z_d    = acc_z;
            trk_dup_d  = acc_dup;
        end

        if (flush_emit) begin
            out_id_d   = trk_id_q;
            out_mask_d = trk_mask_q;
            out_nst_d  = trk_nst_q;
            out_phi_d  = trk_phi_q;
            out_z_d    = trk_z_q;
            out_dup_d  = trk_dup_q;
            open_d     = 1'b0;
        end

        // Start always begins a fresh event; while busy this aborts the current one
        if (start) begin
            state_d     = (number == 6'd0) ? S_DRAIN : S_READ;
            rd_rem_d    = number;
            drain_d     = DRAIN_INIT;
            pipe_d      = '0;
            open_d      = 1'b0;
            trk_id_d    = 7'd0;
            trk_mask_d  = 6'd0;
            trk_nst_d   = 3'd0;
            trk_phi_d   = '0;
            trk_z_d     = '0;
            trk_dup_d   = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_rem_q    <= 6'd0;
            drain_q     <= 3'd0;
            pipe_q      <= '0;
            open_q      <= 1'b0;
            trk_id_q    <= 7'd0;
            trk_mask_q  <= 6'd0;
            trk_nst_q   <= 3'd0;
            trk_phi_q   <= '0;
            trk_z_q     <= '0;
            trk_dup_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 7'd0;
            out_mask_q  <= 6'd0;
            out_nst_q   <= 3'd0;
            out_phi_q   <= '0;
            out_z_q     <= '0;
            out_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_rem_q    <= rd_rem_d;
            drain_q     <= drain_d;
            pipe_q      <= pipe_d;
            open_q      <= open_d;
            trk_id_q    <= trk_id_d;
            trk_mask_q  <= trk_mask_d;
            trk_nst_q   <= trk_nst_d;
            trk_phi_q   <= trk_phi_d;
            trk_z_q     <= trk_z_d;
            trk_dup_q   <= trk_dup_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_mask_q  <= out_mask_d;
            out_nst_q   <= out_nst_d;
            out_phi_q   <= out_phi_d;
            out_z_q     <= out_z_d;
            out_dup_q   <= out_dup_d;
        end
    end

endmodule

// File: tb/tb_fit_residual_sequencer.sv
// Scoreboard bench for fit_residual_sequencer: events are described as word
// lists, a reference model groups them into expected records and done timing,
// and a monitor compares whatever the DUT presents.
module tb_fit_residual_sequencer;

    localparam int RD_LAT = 1;
    localparam int SUM_W  = 14;
    localparam int MAXV   = (1 << (SUM_W - 1)) - 1;
    localparam int MINV   = -(1 << (SUM_W - 1));

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [5:0]       number = 6'd0;
    logic [35:0]      res_in = 36'd0;
    logic             read_en, track_valid, dup_flag, busy, done;
    logic [6:0]       track_id;
    logic [5:0]       layer_mask;
    logic [2:0]       nstubs;
    logic [SUM_W-1:0] sum_phi, sum_z;

    fit_residual_sequencer #(.RD_LAT(RD_LAT), .SUM_W(SUM_W)) dut (
        .clk(clk), .reset(reset), .start(start), .number(number), .res_in(res_in),
        .read_en(read_en), .track_valid(track_valid), .track_id(track_id),
        .layer_mask(layer_mask), .nstubs(nstubs), .sum_phi(sum_phi), .sum_z(sum_z),
        .dup_flag(dup_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] id;
        logic [5:0] mask;
        int         nst;
        int         phi;
        int         z;
        logic       dup;
    } rec_t;

    typedef struct {
        int   cyc;
        int   n;
        logic tv;
    } done_t;

    rec_t        rec_q[$];
    done_t       done_q[$];
    logic [35:0] ev[$];
    int          ptr = 0;
    logic [RD_LAT-1:0] hist = '0;
    int          rd_count = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] mk(input int id, input int l, input int p, input int z);
        return {7'(id), 3'(l), 13'(p), 13'(z)};
    endfunction

    function automatic int sat(input int a, input int b);
        int s;
        s = a + b;
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
        return s;
    endfunction

    // Reference: group the first n words of ev into per-ID runs and predict done timing
    task automatic model_event(input int t0, input int n);
        rec_t cur;
        logic have = 1'b0;
        logic extra = 1'b0;
        logic signed [12:0] p13, z13;
        int layer;
        int bitv;
        cur = '{7'd0, 6'd0, 0, 0, 0, 1'b0};
        for (int i = 0; i < n; i++) begin
            if (ev[i] == 36'd0) continue;
            if (!have || ev[i][35:29] != cur.id) begin
                if (have) begin
                    rec_q.push_back(cur);
                    if (i == n - 1) extra = 1'b1;
                end
                cur = '{ev[i][35:29], 6'd0, 0, 0, 0, 1'b0};
                have = 1'b1;
            end
            layer = int'(ev[i][28:26]);
            bitv = (layer < 6) ? (1 << layer) : 0;
            if (layer >= 6 || (int'(cur.mask) & bitv) != 0) begin
                cur.dup = 1'b1;
            end else begin
                cur.mask = cur.mask | 6'(bitv);
                cur.nst++;
                p13 = ev[i][25:13];
                z13 = ev[i][12:0];
                cur.phi = sat(cur.phi, int'(p13));
                cur.z = sat(cur.z, int'(z13));
            end
        end
        if (have) rec_q.push_back(cur);
        done_q.push_back('{t0 + n + RD_LAT + 1 + (extra ? 1 : 0), n, have});
    endtask

    // One cycle of stimulus: upstream buffer model plus start/number drive
    task automatic step(input logic st, input logic [5:0] num);
        logic deliver;
        @(negedge clk);
        deliver = hist[RD_LAT-1];
        for (int k = RD_LAT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = read_en;
        if (deliver && ptr < ev.size()) begin
            res_in = ev[ptr];
            ptr++;
        end else begin
            res_in = {4'($urandom), 32'($urandom)};
        end
        start = st;
        number = num;
        if (st) begin
            hist = '0;
            ptr = 0;
        end
    endtask

    task automatic run_event(input int n);
        int t0;
        step(1'b1, 6'(n));
        t0 = cyc;
        model_event(t0, n);
        for (int k = 0; k < n + RD_LAT + 5; k++) step(1'b0, 6'd0);
    endtask

    // Monitor: compare every record and done pulse against the scoreboard
    initial begin
        rec_t  r;
        done_t d;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (start) rd_count = 0;
                if (read_en) rd_count++;
                if (track_valid) begin
                    if (rec_q.size() == 0) begin
                        chk("unexpected_record", 1, 0);
                    end else begin
                        r = rec_q.pop_front();
                        chk("rec_id", track_id, r.id);
                        chk("rec_mask", layer_mask, r.mask);
                        chk("rec_nstubs", nstubs, r.nst);
                        chk("rec_sum_phi", int'($signed(sum_phi)), r.phi);
                        chk("rec_sum_z", int'($signed(sum_z)), r.z);
                        chk("rec_dup", dup_flag, r.dup);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("done_with_record", track_valid, d.tv);
                        chk("read_strobes", rd_count, d.n);
                        chk("busy_at_done", busy, 1);
                    end
                end else if (done_q.size() > 0 && cyc > done_q[0].cyc) begin
                    d = done_q.pop_front();
                    chk("done_missing", cyc, d.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        int pool[3];
        int sel;
        // Reset, with a start during reset that must be ignored
        step(1'b0, 6'd0);
        step(1'b1, 6'd5);
        step(1'b0, 6'd0);
        reset = 1'b0;
        step(1'b0, 6'd0);
        chk("reset_outputs", {read_en, track_valid, track_id, layer_mask, nstubs,
                              sum_phi, sum_z, dup_flag, busy, done}, 0);
        step(1'b0, 6'd0);

        // Empty event
        ev.delete();
        run_event(0);

        // Single track, three layers
        ev.delete();
        ev.push_back(mk(5, 0, 10, -4));
        ev.push_back(mk(5, 1, 20, 6));
        ev.push_back(mk(5, 2, -5, 1));
        run_event(3);

        // Two tracks, duplicate layer on the second
        ev.delete();
        ev.push_back(mk(2, 0, 1, 1));
        ev.push_back(mk(2, 1, 2, 2));
        ev.push_back(mk(9, 0, 3, 3));
        ev.push_back(mk(9, 0, 4, 4));
        run_event(4);

        // Positive and negative saturation
        ev.delete();
        for (int l = 0; l < 6; l++) ev.push_back(mk(7, l, 4095, -4096));
        run_event(6);

        // Zero slot and invalid layer
        ev.delete();
        ev.push_back(36'd0);
        ev.push_back(mk(1, 7, 100, 100));
        ev.push_back(mk(1, 3, 12, -12));
        run_event(3);

        // All-zero words
        ev.delete();
        for (int k = 0; k < 3; k++) ev.push_back(36'd0);
        run_event(3);

        // ID change on the final word: last record slips one cycle after FLUSH
        ev.delete();
        ev.push_back(mk(4, 0, 5, 5));
        ev.push_back(mk(4, 2, 6, 6));
        ev.push_back(mk(6, 1, -7, -7));
        run_event(3);

        // Abort: ten-word event restarted at cycle 4 with a one-word event
        ev.delete();
        for (int k = 0; k < 10; k++) ev.push_back(mk(3, k % 6, 9, 9));
        step(1'b1, 6'd10);
        for (int k = 0; k < 3; k++) step(1'b0, 6'd0);
        ev.delete();
        ev.push_back(mk(11, 4, -33, 44));
        run_event(1);

        // Randomized events
        for (int e = 0; e < 40; e++) begin
            n = $urandom_range(0, 20);
            for (int k = 0; k < 3; k++) pool[k] = $urandom_range(0, 127);
            ev.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    ev.push_back(36'd0);
                end else begin
                    sel = $urandom_range(0, 3);
                    if (sel == 0)
                        ev.push_back(mk(pool[$urandom_range(0, 2)], $urandom_range(0, 7), 4095, 4095));
                    else if (sel == 1)
                        ev.push_back(mk(pool[$urandom_range(0, 2)], $urandom_range(0, 7), -4096, -4096));
                    else
                        ev.push_back(mk(pool[$urandom_range(0, 2)], $urandom_range(0, 7),
                                        int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191))));
                end
            end
            run_event(n);
        end

        for (int k = 0; k < 5; k++) step(1'b0, 6'd0);
        chk("records_left", rec_q.size(), 0);
        chk("dones_left", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
